vp_recovery_unit: RTL and testbench
===================================

// Module: vp_recovery_unit
// PURPOSE
//  Responder side of the value-prediction recovery handshake. It captures each issued load-value
//  prediction and checks it against the real D-cache return. On a mismatch it restores the
//  architectural registers from the snapshot, then raises recovery_done until the hazard
//  controller acks, which reloads the PC. It sits between MEM, the register snapshot and the
//  hazard controller.
// PARAMETERS
//  NUM_REGS    32           architectural registers restored; r0 is skipped
//  CNT_W       16           width of the saturating mispredict counter
//  DATA_WIDTH  `DATA_WIDTH  register/data width, from mips_core.svh
//  ADDR_WIDTH  `ADDR_WIDTH  PC width, from mips_core.svh
// PORTS
//  clk                input   1                    clock
//  rst_n              input   1                    synchronous reset, active low
//  pred_valid         input   1                    1-cycle pulse: a prediction was issued to the pipeline
//  pred_data          input   DATA_WIDTH           predicted load value
//  pred_pc            input   ADDR_WIDTH           PC of the predicted load
//  mem_valid          input   1                    D-cache returned the real data for the outstanding load
//  mem_data           input   DATA_WIDTH           real load value
//  snap_regs          input   DATA_WIDTH x NUM_REGS  snapshot contents (stable while busy)
//  rf_we              output  1                    register-file restore write enable
//  rf_waddr           output  5                    restore write address
//  rf_wdata           output  DATA_WIDTH           restore write data = snap_regs[rf_waddr]
//  recover_snapshot   output  1                    level, high for every RESTORE cycle
//  recovery_done      output  1                    level, high in DONE until ack is sampled
//  recovery_done_ack  input   1                    hazard controller has loaded recovery_pc
//  recovery_pc        output  ADDR_WIDTH           captured pred_pc; the PC to refetch from
//  verified           output  1                    1-cycle pulse: prediction matched
//  busy               output  1                    state != IDLE
//  overlap_err        output  1                    sticky: pred_valid arrived while not in IDLE
//  mispredict_cnt     output  CNT_W                saturating count of mismatches
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): state<=IDLE, idx<=1. All outputs go to 0, including the
//    counter and overlap_err. This holds mid-restore as well; partial restores are abandoned.
//  The FSM is fully registered; all outputs decode from registered state/regs.
//  IDLE: pred_valid -> capture pred_data/pred_pc.
//    If mem_valid is also high in the same cycle, compare immediately as in WAIT.
//    Otherwise go to WAIT. mem_valid with no prediction pending is ignored.
//  WAIT: hold until mem_valid, then compare mem_data == captured pred_data (full-width equality).
//    equal   -> verified=1 for exactly the next cycle; return to IDLE.
//    unequal -> mispredict_cnt+1 (saturates at all-ones); go to RESTORE with idx=1.
//  RESTORE: each cycle rf_we=1, rf_waddr=idx, rf_wdata=snap_regs[idx], recover_snapshot=1.
//    idx increments every cycle.
//    At idx==NUM_REGS-1 the write still occurs, then the FSM goes to DONE.
//    The restore lasts exactly NUM_REGS-1 cycles (31); r0 is never written.
//  DONE: recovery_done=1 and recovery_pc is valid.
//    When recovery_done_ack is sampled high -> IDLE; recovery_done drops the next cycle.
//    The ack is level-sensitive; an ack already high on DONE entry completes after 1 DONE cycle.
//  recovery_done_ack is ignored outside DONE.
//  pred_valid outside IDLE is dropped and sets overlap_err.
//    The hazard controller must stall a second load/store while busy.
//  mem_valid in RESTORE/DONE is ignored.
//  rf_we/recover_snapshot are 0 outside RESTORE; verified is 0 except the post-match cycle.
// STRUCTURE
//  mips_core_pkg additions:
//    typedef enum logic [1:0] {VR_IDLE, VR_WAIT, VR_RESTORE, VR_DONE} vp_rec_state_e;
//    localparam VP_FIRST_RESTORE_REG = 5'd1.
//  Sub-module restore_sequencer: idx counter plus rf write-port drive.
//    Handshake start -> done; start pulses when entering RESTORE.
//  The FSM, compare logic and counters live in the top module.
// TESTING
//  1 Prediction match: pred_valid, pred_data=0x1234, 3 idle cycles, then mem_valid with 0x1234
//    -> verified pulse once; rf_we never high; busy high for 4 cycles.
//  2 Mismatch: pred 0xAAAA_0000 at pc 0x0040_0100, mem 0xAAAA_0001
//    -> 31 cycles rf_we, addr 1..31 with data snap_regs[1..31];
//    -> recovery_done high, recovery_pc=0x0040_0100; mispredict_cnt=1.
//  3 Ack handling: hold ack low 5 cycles in DONE -> recovery_done stays high.
//    Raise ack -> IDLE next cycle. Ack pulsed in WAIT -> no effect.
//  4 Same-cycle: pred_valid and mem_valid together in IDLE, equal data
//    -> verified next cycle, never enters WAIT.
//  5 Overlap: second pred_valid during WAIT -> dropped, overlap_err=1, first compare unaffected.
//  6 Reset mid-RESTORE at idx=10
//    -> all outputs 0 next cycle; a fresh mismatch restarts at addr 1.
//    Also: CNT_W=2 with 5 mismatches -> counter saturates at 3.

Source files
------------

// File: rtl/vp_recovery_unit_pkg.sv
// Shared types and constants for the value-prediction recovery unit.
package vp_recovery_unit_pkg;

    typedef enum logic [1:0] {
        VR_IDLE,
        VR_WAIT,
        VR_RESTORE,
        VR_DONE
    } vp_rec_state_e;

    // r0 is hard-wired zero, so restoring starts at r1.
    localparam logic [4:0] VP_FIRST_RESTORE_REG = 5'd1;

endpackage

// File: rtl/vp_recovery_unit_if.sv
// Bundle of the prediction, D-cache, snapshot, register-file and hazard-controller signals.
interface vp_recovery_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int CNT_W      = 16
);
    logic                                 pred_valid;
    logic [DATA_WIDTH-1:0]                pred_data;
    logic [ADDR_WIDTH-1:0]                pred_pc;
    logic                                 mem_valid;
    logic [DATA_WIDTH-1:0]                mem_data;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  snap_regs;
    logic                                 rf_we;
    logic [4:0]                           rf_waddr;
    logic [DATA_WIDTH-1:0]                rf_wdata;
    logic                                 recover_snapshot;
    logic                                 recovery_done;
    logic                                 recovery_done_ack;
    logic [ADDR_WIDTH-1:0]                recovery_pc;
    logic                                 verified;
    logic                                 busy;
    logic                                 overlap_err;
    logic [CNT_W-1:0]                     mispredict_cnt;

    // Pipeline / hazard-controller side.
    modport master (
        output pred_valid, pred_data, pred_pc, mem_valid, mem_data, snap_regs,
               recovery_done_ack,
        input  rf_we, rf_waddr, rf_wdata, recover_snapshot, recovery_done,
               recovery_pc, verified, busy, overlap_err, mispredict_cnt
    );

    // Recovery unit side.
    modport slave (
        input  pred_valid, pred_data, pred_pc, mem_valid, mem_data, snap_regs,
               recovery_done_ack,
        output rf_we, rf_waddr, rf_wdata, recover_snapshot, recovery_done,
               recovery_pc, verified, busy, overlap_err, mispredict_cnt
    );

endinterface

// File: rtl/vp_recovery_unit_restore_sequencer.sv
// Walks r1..r(NUM_REGS-1) one register per cycle and drives the register-file write port.
module vp_recovery_unit_restore_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] snap_regs,
    output logic                                done,
    output logic                                rf_we,
    output logic [4:0]                          rf_waddr,
    output logic [DATA_WIDTH-1:0]               rf_wdata
);
    import vp_recovery_unit_pkg::*;

    localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

    logic       active_q, active_d;
    logic [4:0] idx_q, idx_d;

    // Next index: load on start, advance while active, rewind after the last register.
    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        done     = 1'b0;
        if (start) begin
            active_d = 1'b1;
            idx_d    = VP_FIRST_RESTORE_REG;
        end else if (active_q) begin
            if (idx_q == LAST_REG) begin
                done     = 1'b1;
                active_d = 1'b0;
                idx_d    = VP_FIRST_RESTORE_REG;
            end else begin
                idx_d = idx_q + 5'd1;
            end
        end
    end

    // Sequencer registers; a reset abandons any partial restore.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            idx_q    <= VP_FIRST_RESTORE_REG;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
        end
    end

    // Address and data are forced to zero whenever no write is in progress.
    assign rf_we    = active_q;
    assign rf_waddr = active_q ? idx_q : 5'd0;
    assign rf_wdata = active_q ? snap_regs[idx_q] : '0;

endmodule

// File: rtl/vp_recovery_unit.sv
// Value-prediction recovery responder: captures a prediction, checks it against the D-cache
// return, and on a mismatch restores the register file and hands the PC back.
module vp_recovery_unit #(
    parameter int NUM_REGS   = 32,
    parameter int CNT_W      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    vp_recovery_unit_if.slave  bus
);
    import vp_recovery_unit_pkg::*;

    vp_rec_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0]     pred_data_q, pred_data_d;
    logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
    logic                      verified_q, verified_d;
    logic                      overlap_q, overlap_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      seq_start;
    logic                      seq_done;
    logic                      resolve;
    logic [DATA_WIDTH-1:0]     cmp_ref;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Next state, capture, compare and counter updates.
    always_comb begin
        state_d     = state_q;
        pred_data_d = pred_data_q;
        pc_d        = pc_q;
        verified_d  = 1'b0;
        overlap_d   = overlap_q;
        cnt_d       = cnt_q;
        seq_start   = 1'b0;
        resolve     = 1'b0;
        // In IDLE a same-cycle return is checked against the prediction on the bus.
        cmp_ref     = (state_q == VR_IDLE) ? bus.pred_data : pred_data_q;

        if (bus.pred_valid && (state_q != VR_IDLE)) begin
            overlap_d = 1'b1;
        end

        case (state_q)
            VR_IDLE: begin
                if (bus.pred_valid) begin
                    pred_data_d = bus.pred_data;
                    pc_d        = bus.pred_pc;
                    if (bus.mem_valid) begin
                        resolve = 1'b1;
                    end else begin
                        state_d = VR_WAIT;
                    end
                end
            end
            VR_WAIT: begin
                if (bus.mem_valid) begin
                    resolve = 1'b1;
                end
            end
            VR_RESTORE: begin
                if (seq_done) begin
                    state_d = VR_DONE;
                end
            end
            VR_DONE: begin
                if (bus.recovery_done_ack) begin
                    state_d = VR_IDLE;
                end
            end
            default: state_d = VR_IDLE;
        endcase

        if (resolve) begin
            if (bus.mem_data == cmp_ref) begin
                verified_d = 1'b1;
                state_d    = VR_IDLE;
            end else begin
                cnt_d      = sat_inc(cnt_q);
                state_d    = VR_RESTORE;
                seq_start  = 1'b1;
            end
        end
    end

    // Control and captured-value registers; everything clears on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= VR_IDLE;
            pred_data_q <= '0;
            pc_q        <= '0;
            verified_q  <= 1'b0;
            overlap_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pred_data_q <= pred_data_d;
            pc_q        <= pc_d;
            verified_q  <= verified_d;
            overlap_q   <= overlap_d;
            cnt_q       <= cnt_d;
        end
    end

    vp_recovery_unit_restore_sequencer #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_restore_sequencer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (seq_start),
        .snap_regs (bus.snap_regs),
        .done      (seq_done),
        .rf_we     (bus.rf_we),
        .rf_waddr  (bus.rf_waddr),
        .rf_wdata  (bus.rf_wdata)
    );

    assign bus.recover_snapshot = (state_q == VR_RESTORE);
    assign bus.recovery_done    = (state_q == VR_DONE);
    assign bus.recovery_pc      = pc_q;
    assign bus.verified         = verified_q;
    assign bus.busy             = (state_q != VR_IDLE);
    assign bus.overlap_err      = overlap_q;
    assign bus.mispredict_cnt   = cnt_q;

endmodule

// File: tb/tb_vp_recovery_unit.sv
// Bench for vp_recovery_unit: directed scenarios plus random traffic against a
// transaction-level reference model; a second instance with a 2-bit counter runs in lockstep.
module tb_vp_recovery_unit;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vp_recovery_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .CNT_W(16)) bus ();
    vp_recovery_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .CNT_W(2))  bus2 ();

    assign bus2.pred_valid        = bus.pred_valid;
    assign bus2.pred_data         = bus.pred_data;
    assign bus2.pred_pc           = bus.pred_pc;
    assign bus2.mem_valid         = bus.mem_valid;
    assign bus2.mem_data          = bus.mem_data;
    assign bus2.snap_regs         = bus.snap_regs;
    assign bus2.recovery_done_ack = bus.recovery_done_ack;

    vp_recovery_unit #(.NUM_REGS(NR), .CNT_W(16), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vp_recovery_unit #(.NUM_REGS(NR), .CNT_W(2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] snap_ref [NR];

    // Reference model: a pending compare, a count of restore writes left, a done flag.
    bit            m_pending;
    int            m_left;
    int            m_addr;
    bit            m_done;
    logic [DW-1:0] m_pd;
    logic [AW-1:0] m_pc;
    bit            m_ver;
    int            m_mis;
    bit            m_ovl;

    int n_we, n_ver, n_busy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic resolve(input logic [DW-1:0] d);
        m_pending = 1'b0;
        if (d == m_pd) begin
            m_ver = 1'b1;
        end else begin
            m_mis++;
            m_left = NR - 1;
            m_addr = 1;
        end
    endtask

    task automatic model_update();
        bit busy_before;
        if (!rst_n) begin
            m_pending = 1'b0; m_left = 0; m_addr = 1; m_done = 1'b0;
            m_pd = '0; m_pc = '0; m_ver = 1'b0; m_mis = 0; m_ovl = 1'b0;
        end else begin
            busy_before = m_pending || (m_left > 0) || m_done;
            m_ver = 1'b0;
            if (m_done) begin
                if (bus.recovery_done_ack) m_done = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                m_addr++;
                if (m_left == 0) m_done = 1'b1;
            end else if (m_pending) begin
                if (bus.mem_valid) resolve(bus.mem_data);
            end else if (bus.pred_valid) begin
                m_pd = bus.pred_data;
                m_pc = bus.pred_pc;
                if (bus.mem_valid) resolve(bus.mem_data);
                else m_pending = 1'b1;
            end
            if (bus.pred_valid && busy_before) m_ovl = 1'b1;
        end
    endtask

    task automatic compare_all();
        logic          e_we;
        logic [4:0]    e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_busy;
        int            e_c16, e_c2;
        e_we    = (m_left > 0);
        e_addr  = e_we ? 5'(m_addr) : 5'd0;
        e_wdata = e_we ? snap_ref[m_addr] : '0;
        e_busy  = m_pending || e_we || m_done;
        e_c16   = (m_mis > 65535) ? 65535 : m_mis;
        e_c2    = (m_mis > 3) ? 3 : m_mis;
        chk("rf_we",            bus.rf_we,            e_we);
        chk("rf_waddr",         bus.rf_waddr,         e_addr);
        chk("rf_wdata",         bus.rf_wdata,         e_wdata);
        chk("recover_snapshot", bus.recover_snapshot, e_we);
        chk("recovery_done",    bus.recovery_done,    m_done);
        chk("recovery_pc",      bus.recovery_pc,      m_pc);
        chk("verified",         bus.verified,         m_ver);
        chk("busy",             bus.busy,             e_busy);
        chk("overlap_err",      bus.overlap_err,      m_ovl);
        chk("mispredict_cnt",   bus.mispredict_cnt,   64'(e_c16));
        chk("s_rf_waddr",       bus2.rf_waddr,        e_addr);
        chk("s_recovery_done",  bus2.recovery_done,   m_done);
        chk("s_verified",       bus2.verified,        m_ver);
        chk("s_busy",           bus2.busy,            e_busy);
        chk("s_mispredict_cnt", bus2.mispredict_cnt,  64'(e_c2));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
        if (bus.rf_we)    n_we++;
        if (bus.verified) n_ver++;
        if (bus.busy)     n_busy++;
        bus.pred_valid = 1'b0;
        bus.mem_valid  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 60 && !bus.recovery_done; i++) cyc();
        chk(tag, bus.recovery_done, 1'b1);
    endtask

    task automatic full_mismatch();
        logic [DW-1:0] d;
        d = $urandom();
        bus.pred_valid = 1'b1; bus.pred_data = d; bus.pred_pc = $urandom();
        cyc();
        bus.mem_valid = 1'b1; bus.mem_data = d ^ 32'h1;
        cyc();
        wait_done("mm_reach_done");
        bus.recovery_done_ack = 1'b1;
        cyc();
        bus.recovery_done_ack = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.pred_valid = 1'b0; bus.pred_data = '0; bus.pred_pc = '0;
        bus.mem_valid = 1'b0;  bus.mem_data = '0;  bus.recovery_done_ack = 1'b0;
        for (int i = 0; i < NR; i++) begin
            snap_ref[i]      = $urandom();
            bus.snap_regs[i] = snap_ref[i];
        end
        m_addr = 1;

        // Reset state
        cyc(); cyc();
        chk("rst_rf_we", bus.rf_we, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_cnt", bus.mispredict_cnt, 16'd0);
        rst_n = 1'b1;
        cyc();

        // Prediction match after three idle cycles
        n_we = 0; n_ver = 0; n_busy = 0;
        bus.pred_valid = 1'b1; bus.pred_data = 32'h1234; bus.pred_pc = 32'h0040_0000;
        cyc();
        repeat (3) cyc();
        bus.mem_valid = 1'b1; bus.mem_data = 32'h1234;
        cyc();
        cyc();
        chk("t1_verified_pulses", n_ver, 1);
        chk("t1_rf_we_cycles", n_we, 0);
        chk("t1_busy_cycles", n_busy, 4);

        // Mismatch and full restore
        n_we = 0;
        bus.pred_valid = 1'b1; bus.pred_data = 32'hAAAA_0000; bus.pred_pc = 32'h0040_0100;
        cyc();
        bus.mem_valid = 1'b1; bus.mem_data = 32'hAAAA_0001;
        cyc();
        chk("t2_first_addr", bus.rf_waddr, 5'd1);
        wait_done("t2_reach_done");
        chk("t2_rf_we_cycles", n_we, 31);
        chk("t2_recovery_pc", bus.recovery_pc, 32'h0040_0100);
        chk("t2_cnt", bus.mispredict_cnt, 16'd1);

        // Ack held low keeps DONE, then ack returns to IDLE
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3_done_held", bus.recovery_done, 1'b1);
        end
        bus.recovery_done_ack = 1'b1;
        cyc();
        bus.recovery_done_ack = 1'b0;
        chk("t3_done_dropped", bus.recovery_done, 1'b0);
        chk("t3_idle_after_ack", bus.busy, 1'b0);

        // Ack pulsed during WAIT has no effect
        bus.pred_valid = 1'b1; bus.pred_data = 32'h55; bus.pred_pc = 32'h0040_0200;
        cyc();
        bus.recovery_done_ack = 1'b1;
        cyc();
        bus.recovery_done_ack = 1'b0;
        chk("t3_wait_kept", bus.busy, 1'b1);
        bus.mem_valid = 1'b1; bus.mem_data = 32'h55;
        cyc();
        chk("t3_wait_verified", bus.verified, 1'b1);

        // Same-cycle prediction and return
        n_busy = 0;
        bus.pred_valid = 1'b1; bus.pred_data = 32'h77; bus.pred_pc = 32'h0040_0300;
        bus.mem_valid = 1'b1;  bus.mem_data = 32'h77;
        cyc();
        chk("t4_verified", bus.verified, 1'b1);
        cyc();
        chk("t4_never_busy", n_busy, 0);

        // Overlapping prediction during WAIT
        bus.pred_valid = 1'b1; bus.pred_data = 32'h100; bus.pred_pc = 32'h0040_0400;
        cyc();
        bus.pred_valid = 1'b1; bus.pred_data = 32'h200; bus.pred_pc = 32'h0040_0500;
        cyc();
        chk("t5_overlap", bus.overlap_err, 1'b1);
        bus.mem_valid = 1'b1; bus.mem_data = 32'h100;
        cyc();
        chk("t5_first_verified", bus.verified, 1'b1);
        chk("t5_pc_kept", bus.recovery_pc, 32'h0040_0400);

        // Reset in the middle of a restore
        bus.pred_valid = 1'b1; bus.pred_data = 32'h1; bus.pred_pc = 32'h0040_0600;
        cyc();
        bus.mem_valid = 1'b1; bus.mem_data = 32'h2;
        cyc();
        for (int i = 0; i < 40 && bus.rf_waddr != 5'd10; i++) cyc();
        chk("t6_reached_idx10", bus.rf_waddr, 5'd10);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("t6_rf_we", bus.rf_we, 1'b0);
        chk("t6_rf_waddr", bus.rf_waddr, 5'd0);
        chk("t6_recover", bus.recover_snapshot, 1'b0);
        chk("t6_busy", bus.busy, 1'b0);
        chk("t6_overlap", bus.overlap_err, 1'b0);
        chk("t6_cnt", bus.mispredict_cnt, 16'd0);
        chk("t6_pc", bus.recovery_pc, 32'd0);
        bus.pred_valid = 1'b1; bus.pred_data = 32'h3; bus.pred_pc = 32'h0040_0700;
        cyc();
        bus.mem_valid = 1'b1; bus.mem_data = 32'h4;
        cyc();
        chk("t6_restart_addr", bus.rf_waddr, 5'd1);
        wait_done("t6_reach_done");
        bus.recovery_done_ack = 1'b1;
        cyc();
        bus.recovery_done_ack = 1'b0;

        // Counter saturation on the 2-bit instance
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        repeat (5) full_mismatch();
        chk("sat_cnt2", bus2.mispredict_cnt, 2'd3);
        chk("sat_cnt16", bus.mispredict_cnt, 16'd5);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.pred_valid = 1'b1;
                bus.pred_data  = 32'(($urandom_range(0, 3)) * 32'h0101_0101);
                bus.pred_pc    = $urandom();
            end
            if ($urandom_range(0, 2) == 0) begin
                bus.mem_valid = 1'b1;
                bus.mem_data  = 32'(($urandom_range(0, 3)) * 32'h0101_0101);
            end
            bus.recovery_done_ack = ($urandom_range(0, 2) == 0);
            cyc();
        end
        rst_n = 1'b1;
        bus.recovery_done_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
